// File: rtl/pmcc_sup_pkg.sv
// -----------------------------------------------------------------------------
// pmcc_sup_pkg
// Shared types and constants for the PMCC coprocessor supervisor.
//   CNT_W_DEF : default width of trigger period/count and watchdog counters
//   state_e   : supervisor FSM state encoding
// -----------------------------------------------------------------------------
package pmcc_sup_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_TRIG_DLY,
    ST_TRIG,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pmcc_sup_timer.sv
// -----------------------------------------------------------------------------
// pmcc_sup_timer
// Loadable down-counter with zero flag. Load has priority over decrement;
// decrementing stops at zero.
//   clk, rst_n  : clock, async active-low reset (count clears to 0)
//   load_i      : load load_val_i this cycle
//   load_val_i  : value to load
//   dec_i       : decrement this cycle (ignored when already zero)
//   zero_o      : count is zero
// -----------------------------------------------------------------------------
module pmcc_sup_timer
  import pmcc_sup_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pmcc_supervisor.sv
// -----------------------------------------------------------------------------
// pmcc_supervisor
// Launches a coprocessor program, paces its wait/trigger handshake, guards it
// with a watchdog and arbitrates the code RAM between CPU and coprocessor.
//   clk, rst_n                        : clock, async active-low reset
//   start, stop                       : launch (IDLE only) / abort (while running)
//   trig_period, trig_count, wdt_limit: run configuration, sampled at start
//   cpu_req / cpu_gnt                 : CPU code-RAM request / grant
//   code_sel                          : code-RAM mux, 0 = CPU, 1 = coprocessor
//   pmcc_rst_n                        : registered active-low coprocessor reset
//   waitt                             : coprocessor is executing a wait
//   trigger                           : registered one-cycle trigger pulse
//   busy, done, err_wdt, aborted      : status (done pulses, errors sticky)
//   trig_issued                       : triggers issued in the current/last run
// -----------------------------------------------------------------------------
module pmcc_supervisor
  import pmcc_sup_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] trig_period,
  input  logic [CNT_W-1:0] trig_count,
  input  logic [CNT_W-1:0] wdt_limit,
  input  logic             cpu_req,
  output logic             cpu_gnt,
  output logic             code_sel,
  output logic             pmcc_rst_n,
  output logic             trigger,
  input  logic             waitt,
  output logic             busy,
  output logic             done,
  output logic             err_wdt,
  output logic             aborted,
  output logic [CNT_W-1:0] trig_issued
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, count_q, limit_q;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             err_wdt_q, err_wdt_d;
  logic             aborted_q, aborted_d;
  logic             pmcc_rst_n_q, trigger_q, done_q;
  logic             accept;
  logic             dly_load, dly_dec, dly_zero;
  logic             wdt_load, wdt_dec, wdt_zero;
  logic [CNT_W-1:0] wdt_load_val;

  // Both timers transition when they read zero, so they are loaded with the
  // programmed value minus one: a delay of N gives N idle cycles, a watchdog
  // limit of N trips after N non-waiting cycles. 0 and 1 behave alike.
  function automatic logic [CNT_W-1:0] dec1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // The first watchdog load happens in the start cycle, before limit_q is set.
  assign wdt_load_val = accept ? dec1(wdt_limit) : dec1(limit_q);

  pmcc_sup_timer #(.W(CNT_W)) u_dly_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (dly_load),
    .load_val_i(dec1(period_q)),
    .dec_i     (dly_dec),
    .zero_o    (dly_zero)
  );

  pmcc_sup_timer #(.W(CNT_W)) u_wdt_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (wdt_load),
    .load_val_i(wdt_load_val),
    .dec_i     (wdt_dec),
    .zero_o    (wdt_zero)
  );

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    issued_d  = issued_q;
    err_wdt_d = err_wdt_q;
    aborted_d = aborted_q;
    accept    = 1'b0;
    dly_load  = 1'b0;
    dly_dec   = 1'b0;
    wdt_load  = 1'b0;
    wdt_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // stop is meaningless here and is dropped, even alongside start.
        if (start) begin
          state_d   = ST_RUN;
          accept    = 1'b1;
          issued_d  = '0;
          err_wdt_d = 1'b0;
          aborted_d = 1'b0;
          wdt_load  = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (waitt) begin
          wdt_load = 1'b1;
          if (issued_q < count_q) begin
            state_d  = ST_TRIG_DLY;
            dly_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if ((limit_q != '0) && wdt_zero) begin
          state_d   = ST_IDLE;
          err_wdt_d = 1'b1;
        end else begin
          wdt_dec = 1'b1;
        end
      end
      ST_TRIG_DLY: begin
        if (stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (dly_zero) begin
          // Count the trigger as it is entered so trig_issued and trigger
          // rise together.
          state_d  = ST_TRIG;
          issued_d = (issued_q == '1) ? issued_q : issued_q + CNT_W'(1);
        end else begin
          dly_dec = 1'b1;
        end
      end
      ST_TRIG: begin
        if (stop) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else begin
          state_d  = ST_RUN;
          wdt_load = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issued_q     <= '0;
      err_wdt_q    <= 1'b0;
      aborted_q    <= 1'b0;
      pmcc_rst_n_q <= 1'b0;
      trigger_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      err_wdt_q    <= err_wdt_d;
      aborted_q    <= aborted_d;
      // Outputs registered from the next state so they align with state_q.
      pmcc_rst_n_q <= (state_d != ST_IDLE);
      trigger_q    <= (state_d == ST_TRIG);
      done_q       <= (state_d == ST_DONE);
    end
  end

  // NOTE: configuration registers are reset too; they are plain flops, not a
  // memory array, and a known value keeps reset state fully deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= '0;
      count_q  <= '0;
      limit_q  <= '0;
    end else if (accept) begin
      period_q <= trig_period;
      count_q  <= trig_count;
      limit_q  <= wdt_limit;
    end
  end

  // Grant drops in the very cycle start is accepted; code_sel follows the
  // coprocessor reset release so the mux never switches early.
  assign cpu_gnt     = (state_q == ST_IDLE) && cpu_req && !start;
  assign code_sel    = pmcc_rst_n_q;
  assign pmcc_rst_n  = pmcc_rst_n_q;
  assign trigger     = trigger_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err_wdt     = err_wdt_q;
  assign aborted     = aborted_q;
  assign trig_issued = issued_q;

endmodule

// File: doc/pmcc_supervisor.md
PMCC_SUPERVISOR -- requirements
Module: pmcc_supervisor

Interface
REQ-001 Parameter CNT_W, default 16, width of trigger period, trigger count and watchdog counters.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to launch the coprocessor program; honoured only in IDLE.
REQ-005 stop  input  1  one-cycle abort request; honoured in any state except IDLE.
REQ-006 trig_period  input  CNT_W  idle cycles between coprocessor entering wait and the trigger pulse; sampled at start.
REQ-007 trig_count  input  CNT_W  number of triggers to issue per run; sampled at start.
REQ-008 wdt_limit  input  CNT_W  max consecutive non-waiting RUN cycles; 0 disables; sampled at start.
REQ-009 cpu_req  input  1  CPU request for code-RAM access.
REQ-010 cpu_gnt  output  1  CPU granted code RAM this cycle.
REQ-011 code_sel  output  1  code-RAM port mux select: 0 = CPU, 1 = coprocessor fetch.
REQ-012 pmcc_rst_n  output  1  active-low coprocessor reset, registered.
REQ-013 trigger  output  1  coprocessor trigger pulse, registered.
REQ-014 waitt  input  1  coprocessor wait-instruction decode.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on successful completion.
REQ-017 err_wdt  output  1  sticky watchdog error, cleared by next accepted start.
REQ-018 aborted  output  1  sticky abort flag, cleared by next accepted start.
REQ-019 trig_issued  output  CNT_W  triggers issued in current/last run.

Function
REQ-020 FSM states: IDLE, RUN, TRIG_DLY, TRIG, DONE.
REQ-021 IDLE: pmcc_rst_n=0, code_sel=0, cpu_gnt=cpu_req; start -> RUN, clears trig_issued, err_wdt, aborted, latches trig_period/trig_count/wdt_limit.
REQ-022 RUN: pmcc_rst_n=1, code_sel=1, cpu_gnt=0; waitt=1 and trig_issued<trig_count -> TRIG_DLY loading delay counter with trig_period; waitt=1 and trig_issued==trig_count -> DONE.
REQ-023 RUN watchdog: counts cycles with waitt=0; reaching wdt_limit (nonzero) -> IDLE with err_wdt=1; counter clears whenever waitt=1 or on entry to RUN.
REQ-024 TRIG_DLY: delay counter decrements each cycle; at 0 -> TRIG; trig_period=0 -> TRIG on the next cycle.
REQ-025 TRIG: trigger=1 for exactly one cycle, trig_issued increments (saturating at 2^CNT_W-1), -> RUN.
REQ-026 trigger never asserted outside TRIG; two triggers are at least trig_period+2 cycles apart.
REQ-027 DONE: done=1 for one cycle, -> IDLE; pmcc_rst_n deasserts (goes 0) on IDLE entry.
REQ-028 stop in RUN/TRIG_DLY/TRIG -> IDLE next cycle with aborted=1; stop wins over simultaneous waitt, watchdog expiry or trigger issue; trigger is not asserted in the stop cycle's successor.
REQ-029 start while busy, and stop in IDLE, are ignored with no side effect.
REQ-030 start and stop together in IDLE: start taken, stop ignored.
REQ-031 trig_count=0: first waitt in RUN -> DONE, no trigger issued.
REQ-032 cpu_gnt deasserts the same cycle start is accepted; code_sel switches to 1 together with pmcc_rst_n rising, never before.

Reset
REQ-033 rst_n low: state=IDLE, pmcc_rst_n=0, trigger=0, done=0, busy=0, err_wdt=0, aborted=0, trig_issued=0, code_sel=0, counters=0; cpu_gnt follows cpu_req combinationally.
REQ-034 Reset asserted mid-run takes effect immediately and asynchronously; no done pulse is generated.

Structure
REQ-035 Package pmcc_sup_pkg holds the state enum and default CNT_W constant.
REQ-036 One sub-module pmcc_sup_timer: loadable CNT_W down-counter with zero flag, instanced twice (trigger delay, watchdog).

Verification
REQ-037 trig_period=3, trig_count=2, waitt high 5 cycles after start each time -> two 1-cycle trigger pulses 4 cycles after each waitt rise, then done, trig_issued=2.
REQ-038 trig_count=0, waitt rises 10 cycles after start -> done one cycle later, trigger never asserted, pmcc_rst_n returns 0.
REQ-039 wdt_limit=8, waitt held 0 -> err_wdt=1 and IDLE 8 cycles after RUN entry; no done.
REQ-040 stop asserted in TRIG_DLY with trig_period=5 -> IDLE next cycle, aborted=1, no trigger.
REQ-041 cpu_req held high across start -> cpu_gnt=1 in IDLE, 0 from start cycle, 1 again after done.
REQ-042 rst_n pulsed low during TRIG_DLY -> all outputs at reset values asynchronously, start then runs normally.
